// File: rtl/pdm_decoder.sv
// PDM receiver: CIC decimator (integrators at bit rate, combs at R-decimated rate) plus saturation.
// Define PDM_DECODER_SYNC_EN to put din through a two-flop synchronizer for off-chip sources.
module pdm_decoder #(
  parameter int unsigned NBITS      = 24,
  parameter int unsigned LOG2_DECIM = 8,
  parameter int unsigned ORDER      = 3
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             din,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  output logic             clip
);

  localparam int unsigned W     = ORDER * LOG2_DECIM + 1;
  localparam int unsigned SHIFT = ORDER * LOG2_DECIM - NBITS;

  if (ORDER < 1 || ORDER > 4) begin : g_bad_order
    $error("pdm_decoder: ORDER must be in 1..4");
  end
  if (ORDER * LOG2_DECIM < NBITS) begin : g_bad_width
    $error("pdm_decoder: ORDER*LOG2_DECIM must be >= NBITS");
  end

  logic x_q;
  logic en_q;

`ifdef PDM_DECODER_SYNC_EN
  logic din_meta_q;
  logic en_meta_q;

  // enable is delayed alongside din so it keeps qualifying the same bit
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      din_meta_q <= 1'b0;
      en_meta_q  <= 1'b0;
      x_q        <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      din_meta_q <= din;
      en_meta_q  <= enable;
      x_q        <= din_meta_q;
      en_q       <= en_meta_q;
    end
  end
`else
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      x_q  <= 1'b0;
      en_q <= 1'b0;
    end else begin
      x_q  <= din;
      en_q <= enable;
    end
  end
`endif

  logic [LOG2_DECIM-1:0] cnt_q;
  logic [W-1:0]          integ_q [ORDER];
  logic                  strobe;

  assign strobe = en_q && (cnt_q == '1);

  // Integrators wrap modulo 2^W by design; the combs undo the wrap.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      for (int unsigned k = 0; k < ORDER; k++) integ_q[k] <= '0;
    end else if (en_q) begin
      cnt_q      <= cnt_q + LOG2_DECIM'(1);
      integ_q[0] <= integ_q[0] + W'(x_q);
      for (int unsigned k = 1; k < ORDER; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
    end
  end

  logic [W-1:0]   comb_q  [ORDER+1];
  logic [W-1:0]   delay_q [ORDER];
  logic [ORDER:0] stage_vld_q;

  // The comb pipeline ignores enable so a started sample always completes.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      stage_vld_q <= '0;
      for (int unsigned k = 0; k <= ORDER; k++) comb_q[k] <= '0;
      for (int unsigned k = 0; k < ORDER; k++) delay_q[k] <= '0;
    end else begin
      stage_vld_q <= {stage_vld_q[ORDER-1:0], strobe};
      if (strobe) comb_q[0] <= integ_q[ORDER-1];
      for (int unsigned k = 1; k <= ORDER; k++) begin
        if (stage_vld_q[k-1]) begin
          comb_q[k]    <= comb_q[k-1] - delay_q[k-1];
          delay_q[k-1] <= comb_q[k-1];
        end
      end
    end
  end

  logic [W-1:0] y;
  logic         sat;

  assign y   = comb_q[ORDER] >> SHIFT;
  assign sat = |y[W-1:NBITS];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      clip       <= 1'b0;
    end else begin
      dout_valid <= stage_vld_q[ORDER];
      if (stage_vld_q[ORDER]) begin
        dout <= sat ? '1 : y[NBITS-1:0];
        clip <= sat;
      end
    end
  end

endmodule

// File: tb/tb_pdm_decoder.sv
// Scoreboard bench for pdm_decoder: stimulus queues expected samples with arrival cycles,
// a monitor pops one entry on every dout_valid pulse.
module tb_pdm_decoder;

`ifdef PDM_DECODER_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        enable;
  logic        din;
  logic [23:0] dout;
  logic        dout_valid;
  logic        clip;

  pdm_decoder dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .enable     (enable),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .clip       (clip)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          at;
    bit          chk;
    logic [23:0] val;
    bit          clp;
    int          tol;
  } exp_t;

  exp_t        q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          base        = 0;
  bit          lb          = 1'b0;
  bit          alt         = 1'b0;
  logic [23:0] acc         = '0;

  initial begin
    exp_t e;
    int   d;
    bit   ok;
    forever begin
      @(negedge CLOCK_50);
      if (dout_valid === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid cycle=%0d dout=%h clip=%b", cyc, dout, clip);
        end else begin
          e  = q.pop_front();
          ok = (cyc == e.at);
          if (e.chk) begin
            d = int'(dout) - int'(e.val);
            if (d < 0) d = -d;
            ok = ok && (d <= e.tol) && (clip === e.clp);
          end
          if (!ok) begin
            miscompares++;
            $display("FAIL %s got cycle=%0d dout=%h clip=%b want cycle=%0d dout=%h(+-%0h) clip=%b chk=%b",
                     e.name, cyc, dout, clip, e.at, e.val, e.tol, e.clp, e.chk);
          end
        end
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Inputs change 5 units after a rising edge, well clear of both clock edges.
  task automatic step();
    logic [24:0] s;
    @(posedge CLOCK_50);
    #5;
    if (lb) begin
      s   = {1'b0, acc} + 25'h0400000;
      din = s[24];
      acc = s[23:0];
    end else if (alt) begin
      din = ~din;
    end
  endtask

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_now("rst_dout", 32'(dout), 32'h0);
    check_now("rst_valid", 32'(dout_valid), 32'h0);
    check_now("rst_clip", 32'(clip), 32'h0);
    q.delete();
    step();
    step();
    reset = 1'b0;
    base  = cyc;
  endtask

  task automatic push_exp(input string name, input int idx, input int gap, input bit chk,
                          input logic [23:0] val, input bit clp, input int tol);
    exp_t e;
    e.name = name;
    e.at   = base + 256 + 3 + 1 + L + 256 * idx + gap;
    e.chk  = chk;
    e.val  = val;
    e.clp  = clp;
    e.tol  = tol;
    q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout pending=%0d want=0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    din    = 1'b0;
    step();
    step();
    check_now("init_dout", 32'(dout), 32'h0);
    check_now("init_valid", 32'(dout_valid), 32'h0);

    // Silence: every sample zero, exactly 256 cycles apart.
    enable = 1'b1;
    din    = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) push_exp("zero", i, 0, 1'b1, 24'h000000, 1'b0, 0);
    wait_drain("zero", 5 * 256 + 400);

    // Full scale saturates once settled.
    din = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) push_exp("ones", i, 0, i >= 3, 24'hFFFFFF, 1'b1, 0);
    wait_drain("ones", 5 * 256 + 400);

    // Alternating bits decode to exactly half scale.
    din = 1'b0;
    alt = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) push_exp("alt", i, 0, i >= 3, 24'h800000, 1'b0, 0);
    wait_drain("alt", 5 * 256 + 400);
    alt = 1'b0;

    // 100-cycle enable gap inside the fifth frame delays later samples by 100.
    din = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) push_exp("gap", i, (i >= 4) ? 100 : 0, i >= 3, 24'hFFFFFF, 1'b1, 0);
    while (cyc < base + 1100) step();
    enable = 1'b0;
    repeat (100) step();
    enable = 1'b1;
    wait_drain("gap", 3 * 256 + 400);

    // Loopback from a first-order PDM modulator at quarter scale.
    acc = '0;
    din = 1'b0;
    do_reset();
    lb = 1'b1;
    for (int i = 0; i < 20; i++) push_exp("loop", i, 0, i >= 3, 24'h400000, 1'b0, 24'h1000);
    wait_drain("loop", 20 * 256 + 400);
    lb = 1'b0;

    // Reset between edges with a sample in the comb pipeline.
    din = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) push_exp("pre_rst", i, 0, i == 3, 24'hFFFFFF, 1'b1, 0);
    while (cyc < base + 1282) step();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pre_rst_drain pending=%0d want=0", q.size());
    end
    check_now("pre_rst_dout", 32'(dout), 32'h00FFFFFF);
    do_reset();
    for (int i = 0; i < 4; i++) push_exp("post_rst", i, 0, i == 3, 24'hFFFFFF, 1'b1, 0);
    wait_drain("post_rst", 4 * 256 + 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pdm_decoder.md
# pdm_decoder

Pulse-density-modulation receiver. It converts a 1-bit PDM stream clocked at CLOCK_50 back into unsigned amplitude samples at the decimated audio rate of about 195.3 kHz. It is the inverse of the synth's PDM output path and is used for loopback self-test of the audio chain and for PDM microphone input. The core is a CIC decimation filter (integrators at full rate, combs at the decimated rate) followed by an output saturation stage.

## Interface
Parameters:
- NBITS, 24: output sample width; matches the amplitude type width.
- LOG2_DECIM, 8: log2 of the decimation ratio R (R = 256).
- ORDER, 3: CIC order, legal range 1..4.
- Elaboration error if ORDER*LOG2_DECIM < NBITS.

Ports:
- CLOCK_50  in  1  system clock; also the PDM bit clock.
- reset  in  1  asynchronous, active-high; clock CLOCK_50.
- enable  in  1  qualifies din; when low, the integrators and the decimation counter hold.
- din  in  1  PDM bit; 1 maps to +1, 0 maps to 0.
- dout  out  NBITS  decoded sample, unsigned.
- dout_valid  out  1  single-cycle pulse when dout updates.
- clip  out  1  high alongside dout_valid when the sample saturated; low otherwise.

## Operation
- Internal width W = ORDER*LOG2_DECIM+1, which is 25 bits at the defaults.
- All integrator and comb arithmetic is modulo 2^W. Integrator wrap-around is legal and must not be detected or corrected.
- Input register: din is sampled into bit x (see Configuration for the sampling stage).
- Integrators: on each enabled cycle, I1 += x and Ik += I(k-1), with all stages updating simultaneously from their previous values.
- Decimation counter cnt, range 0..R-1:
  - Increments on each enabled cycle and wraps from R-1 to 0.
  - Strobe = enable && cnt == R-1.
- Comb pipeline, one register per stage:
  - On strobe the last integrator is captured into C0.
  - Stage k computes Ck = C(k-1) - D(k-1), and the delay Dk-1 is loaded with C(k-1).
  - Delay registers update only when their stage advances.
- Output stage:
  - y = C_ORDER >> (ORDER*LOG2_DECIM - NBITS).
  - If y > 2^NBITS-1: dout = all ones and clip = 1. Otherwise dout = y[NBITS-1:0] and clip = 0.
  - The only value that can saturate is full scale R^ORDER (din constantly 1).
- The comb and output pipeline always runs to completion once started, regardless of enable.
- The first ORDER output samples after reset are CIC settling transients. They are still flagged with dout_valid.
- Reset values: all integrators, combs, delays and cnt are 0; dout = 0, dout_valid = 0, clip = 0.
- Reset asserted mid-operation clears all state immediately, including an in-flight comb pipeline. No dout_valid pulse occurs while reset is high.

## Timing
- Strobe cycle t (the cycle with cnt == R-1 and enable high): C0 registers at the t edge.
- Comb stage k registers at t+k for k = 1..ORDER.
- dout, clip and dout_valid register at t+ORDER+1. dout_valid is high for that cycle only.
- dout and clip hold until the next valid pulse.
- Output period is R enabled cycles. Each cycle with enable low delays the next strobe by exactly one cycle.
- After reset deassertion with enable held high, the first dout_valid occurs at clock edge R+ORDER+1+L. L is the input latency from Configuration: 1 without the macro, 2 with it.
- Cadence: strobes are R ≥ 2 cycles apart and the pipeline depth is ORDER+1 ≤ R, so consecutive samples never collide in the pipeline.
- Throughput: one sample per R enabled cycles. No backpressure; the consumer must take dout on dout_valid.

## Configuration
- PDM_DECODER_SYNC_EN defined: din passes through a two-flop synchronizer before reaching x (L = 2). Use this for an asynchronous off-chip PDM source.
- Macro undefined: din is registered once into x (L = 1). Use this for on-chip loopback from the PDM output.
- All other behaviour is identical with and without the macro.

## Test plan
- din = 0 constant, enable = 1: every dout_valid gives dout = 0x000000 and clip = 0. The valid pulses are exactly 256 cycles apart.
- din = 1 constant: after the settling outputs, dout = 0xFFFFFF with clip = 1 on every valid pulse.
- din alternating 1,0,1,0: after settling, dout = 0x800000 exactly with clip = 0.
- Loopback from the PDM output path (first-order PDM, NBITS = 24) driven with 0x400000, run for 20 samples: the settled dout is within ±0x1000 of 0x400000.
- enable low for 100 cycles mid-frame with din = 1 constant: the next dout_valid arrives 100 cycles later than nominal, the value is unchanged, and cnt does not advance while enable is low.
- reset pulsed mid-frame, asynchronously between clock edges:
  - dout and dout_valid go to 0 immediately and no pending valid pulse emerges.
  - The first valid after release occurs at edge 256+4+L.
